uart_reg_responder: RTL

Register-access responder that turns the full-duplex UART into a host-controlled register port. It parses command frames from the UART receiver byte stream, reads or writes a small local register file, and returns acknowledge/data bytes through the UART transmitter. It sits beside the duplex UART top, wired to its receiver outputs and transmitter inputs. It acts as the responder end of a host-initiated command protocol.

---
 rtl/uart_resp_pkg.sv | 36 +++
 rtl/uart_reg_responder_if.sv | 23 ++
 rtl/uart_resp_regfile.sv | 40 ++++
 rtl/uart_reg_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_resp_pkg.sv
// Shared constants, state encoding and payload types for the UART register responder.
// Optional request/response checksums are enabled by UART_RESP_CHECKSUM_EN.
package uart_resp_pkg;

   localparam logic [7:0] OP_RD       = 8'h52;
   localparam logic [7:0] OP_WR       = 8'h57;
   localparam logic [7:0] ACK         = 8'h41;
   localparam logic [7:0] NACK        = 8'h4E;
   localparam logic [7:0] STATUS_ADDR = 8'h0F;

   localparam int unsigned RESP_DEPTH = 3;
   localparam int unsigned IDX_W      = 2;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
`ifdef UART_RESP_CHECKSUM_EN
      GET_CSUM,
`endif
      EXEC,
      SEND_REQ,
      SEND_WAIT
   } state_e;

   // Received byte together with the error flags captured alongside it
   typedef struct packed {
      logic [7:0] data;
      logic [2:0] err;
   } rx_byte_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_reg_responder_if.sv
// UART-side connection of the register responder: receiver outputs in, transmitter controls out.
interface uart_reg_responder_if;

   logic [7:0] rx_data;
   logic       rx_done;
   logic [2:0] rx_error;
   logic       tx_done;
   logic       tx_active;
   logic       tx_send;
   logic [7:0] tx_data;

   // master is the UART side, slave is the responder
   modport master (
      output rx_data, rx_done, rx_error, tx_done, tx_active,
      input  tx_send, tx_data
   );

   modport slave (
      input  rx_data, rx_done, rx_error, tx_done, tx_active,
      output tx_send, tx_data
   );

endinterface

// File: rtl/uart_resp_regfile.sv
// Byte register file: synchronous write port, combinational read mux with the status byte at 0xF.
module uart_resp_regfile
   import uart_resp_pkg::*;
#(
   parameter  int unsigned NUM_REGS = 15,
   localparam int unsigned AW       = idx_width(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [7:0]    raddr,
   input  logic [7:0]    status_in,
   output logic [7:0]    rdata_c,
   output logic [7:0]    ctrl_out
);

   logic [7:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '{default: '0};
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_c = '0;
      if (raddr == STATUS_ADDR) begin
         rdata_c = status_in;
      end else if (raddr < 8'(NUM_REGS)) begin
         rdata_c = regs[raddr[AW-1:0]];
      end
   end

   assign ctrl_out = regs[0];

endmodule

// File: rtl/uart_reg_responder.sv
// Host-driven register port over UART: parses read/write frames and answers with ACK/data or NACK.
// Define UART_RESP_CHECKSUM_EN to add XOR checksums to requests and ACK responses.
module uart_reg_responder
   import uart_resp_pkg::*;
#(
   parameter  int unsigned NUM_REGS       = 15,
   parameter  int unsigned TIMEOUT_CYCLES = 1_000_000,
   localparam int unsigned AW             = idx_width(NUM_REGS),
   localparam int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                rst,
   uart_reg_responder_if.slave uart,
   input  logic [7:0]          status_in,
   output logic [7:0]          ctrl_out,
   output logic                busy
);

   state_e state_q, state_nxt;

   logic     rx_done_q, rx_evt_q, tx_done_q, tx_evt_q;
   rx_byte_t rx_q;

   logic                              wr_q, wr_nxt;
   logic [7:0]                        addr_q, addr_nxt;
   logic [7:0]                        data_q, data_nxt;
   logic [RESP_DEPTH-1:0][7:0]        resp_q, resp_nxt;
   logic [IDX_W-1:0]                  len_q, len_nxt;
   logic [IDX_W-1:0]                  idx_q, idx_nxt;
   logic [TW-1:0]                     tmo_q, tmo_nxt;
`ifdef UART_RESP_CHECKSUM_EN
   logic [7:0]                        csum_q, csum_nxt;
`endif
   logic                              we, nack, get_state;
   logic [7:0]                        rdata_c;

   uart_resp_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .waddr     (addr_q[AW-1:0]),
      .wdata     (data_q),
      .raddr     (addr_q),
      .status_in (status_in),
      .rdata_c   (rdata_c),
      .ctrl_out  (ctrl_out)
   );

   // Rising-edge detection of the UART done flags; the byte is latched with its event
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_done_q <= 1'b0;
         rx_evt_q  <= 1'b0;
         rx_q      <= '0;
         tx_done_q <= 1'b0;
         tx_evt_q  <= 1'b0;
      end else begin
         rx_done_q <= uart.rx_done;
         rx_evt_q  <= uart.rx_done & ~rx_done_q;
         if (uart.rx_done & ~rx_done_q) begin
            rx_q <= '{data: uart.rx_data, err: uart.rx_error};
         end
         tx_done_q <= uart.tx_done;
         tx_evt_q  <= uart.tx_done & ~tx_done_q;
      end
   end

   always_comb begin
      get_state = (state_q == GET_ADDR) || (state_q == GET_DATA)
`ifdef UART_RESP_CHECKSUM_EN
                  || (state_q == GET_CSUM)
`endif
                  ;
   end

   always_comb begin
      state_nxt = state_q;
      wr_nxt    = wr_q;
      addr_nxt  = addr_q;
      data_nxt  = data_q;
      resp_nxt  = resp_q;
      len_nxt   = len_q;
      idx_nxt   = idx_q;
      tmo_nxt   = '0;
      we        = 1'b0;
      nack      = 1'b0;
`ifdef UART_RESP_CHECKSUM_EN
      csum_nxt  = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (rx_evt_q) begin
               if (rx_q.err != '0 || (rx_q.data != OP_RD && rx_q.data != OP_WR)) begin
                  nack = 1'b1;
               end else begin
                  wr_nxt    = (rx_q.data == OP_WR);
                  state_nxt = GET_ADDR;
`ifdef UART_RESP_CHECKSUM_EN
                  csum_nxt  = rx_q.data;
`endif
               end
            end
         end
         GET_ADDR: begin
            if (rx_evt_q) begin
               if (rx_q.err != '0) begin
                  nack = 1'b1;
               end else begin
                  addr_nxt = rx_q.data;
`ifdef UART_RESP_CHECKSUM_EN
                  csum_nxt  = csum_q ^ rx_q.data;
                  state_nxt = wr_q ? GET_DATA : GET_CSUM;
`else
                  state_nxt = wr_q ? GET_DATA : EXEC;
`endif
               end
            end
         end
         GET_DATA: begin
            if (rx_evt_q) begin
               if (rx_q.err != '0) begin
                  nack = 1'b1;
               end else begin
                  data_nxt = rx_q.data;
`ifdef UART_RESP_CHECKSUM_EN
                  csum_nxt  = csum_q ^ rx_q.data;
                  state_nxt = GET_CSUM;
`else
                  state_nxt = EXEC;
`endif
               end
            end
         end
`ifdef UART_RESP_CHECKSUM_EN
         GET_CSUM: begin
            if (rx_evt_q) begin
               if (rx_q.err != '0 || rx_q.data != csum_q) begin
                  nack = 1'b1;
               end else begin
                  state_nxt = EXEC;
               end
            end
         end
`endif
         EXEC: begin
            idx_nxt     = '0;
            state_nxt   = SEND_REQ;
            resp_nxt[0] = ACK;
            if (wr_q) begin
               if (addr_q < 8'(NUM_REGS)) begin
                  we      = 1'b1;
                  len_nxt = IDX_W'(1);
`ifdef UART_RESP_CHECKSUM_EN
                  resp_nxt[1] = ACK;
                  len_nxt     = IDX_W'(2);
`endif
               end else begin
                  nack = 1'b1;
               end
            end else if (addr_q < 8'(NUM_REGS) || addr_q == STATUS_ADDR) begin
               resp_nxt[1] = rdata_c;
               len_nxt     = IDX_W'(2);
`ifdef UART_RESP_CHECKSUM_EN
               resp_nxt[2] = ACK ^ rdata_c;
               len_nxt     = IDX_W'(3);
`endif
            end else begin
               nack = 1'b1;
            end
         end
         SEND_REQ: begin
            if (uart.tx_active) begin
               state_nxt = SEND_WAIT;
            end
         end
         SEND_WAIT: begin
            if (tx_evt_q) begin
               if (idx_q + IDX_W'(1) < len_q) begin
                  idx_nxt   = idx_q + IDX_W'(1);
                  state_nxt = SEND_REQ;
               end else begin
                  idx_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A byte in the same cycle as expiry wins; the counter stays cleared
      if (get_state && !rx_evt_q) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
            tmo_nxt   = tmo_q;
            state_nxt = IDLE;
         end else begin
            tmo_nxt = tmo_q + TW'(1);
         end
      end

      if (nack) begin
         resp_nxt[0] = NACK;
         len_nxt     = IDX_W'(1);
         idx_nxt     = '0;
         state_nxt   = SEND_REQ;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         resp_q       <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         tmo_q        <= '0;
`ifdef UART_RESP_CHECKSUM_EN
         csum_q       <= '0;
`endif
         uart.tx_send <= 1'b0;
         uart.tx_data <= '0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         wr_q         <= wr_nxt;
         addr_q       <= addr_nxt;
         data_q       <= data_nxt;
         resp_q       <= resp_nxt;
         len_q        <= len_nxt;
         idx_q        <= idx_nxt;
         tmo_q        <= tmo_nxt;
`ifdef UART_RESP_CHECKSUM_EN
         csum_q       <= csum_nxt;
`endif
         uart.tx_send <= (state_nxt == SEND_REQ);
         if (state_nxt == SEND_REQ) begin
            uart.tx_data <= resp_nxt[idx_nxt];
         end
         busy         <= (state_nxt != IDLE);
      end
   end

endmodule
